dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the memory-stage external interface; it is the memory-side end of ext_mem_addr/wdata/write/read/rdata/ready.
- Holds a word-addressed 32-bit RAM and accepts one read or write request at a time.
- Returns data and a one-cycle ready pulse after a programmable wait.
- Byte and halfword merging is done by the requester, so every write from the requester is a full 32-bit word.

Parameters:
- DEPTH_LOG2, 12: RAM holds 2**DEPTH_LOG2 32-bit words; valid word addresses are 0 to 2**DEPTH_LOG2-1.
- WAIT_CYCLES, 0: extra BUSY cycles per access (0 to 15).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ext_mem_addr  in  16  word address from the requester.
- ext_mem_wdata  in  32  write data, a full pre-merged word.
- ext_mem_write  in  1  write request, level, held until ready.
- ext_mem_read  in  1  read request, level, held until ready.
- ext_mem_rdata  out  32  read data, registered.
- ext_mem_ready  out  1  access-complete pulse, registered.
- busy  out  1  high in BUSY and DONE.
- addr_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (asynchronous, any cycle):
  - state=IDLE, ext_mem_rdata=0, ext_mem_ready=0, busy=0, addr_err=0, wait counter=0.
  - RAM contents are not reset.
  - An access in flight is aborted and its write is not committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If ext_mem_write or ext_mem_read is high at an edge, capture addr, wdata and op (write has priority when both are high; see below).
  - Load the counter with WAIT_CYCLES and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; only the captured values are used.
  - While counter != 0: decrement and stay.
  - When counter == 0, the access executes at that edge:
    - Read: ext_mem_rdata <= RAM[addr].
    - Write: RAM[addr] <= wdata, and ext_mem_rdata <= the old RAM[addr] (read-before-write).
    - ext_mem_ready <= 1, then go to DONE.
- DONE:
  - Inputs are ignored for exactly this cycle, so a request still held from the finishing access is not re-issued.
  - At the next edge: ext_mem_ready <= 0, go to IDLE.
- Latency: request first sampled at edge N → ready high during the cycle after edge N+1+WAIT_CYCLES, for exactly one cycle. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- ext_mem_rdata holds its value until the next completed access or reset.
- Read and write both high: treated as a write. The rdata returned is the pre-write word.
- Out of range (addr[15:DEPTH_LOG2] != 0):
  - A write is dropped and RAM is unchanged.
  - A read returns 0.
  - Ready still pulses with normal timing.
  - addr_err is set at the completion edge and cleared only by reset.
- Input changes during BUSY or DONE never alter the captured access.

Optional Feature:
- Macro: DMEM_WAIT_LFSR_EN.
- When defined:
  - A 7-bit LFSR (x^7+x^6+1, seed 7'h5A after reset) advances every clk.
  - In IDLE, the counter is loaded with WAIT_CYCLES plus LFSR[1:0], giving 0 to 3 extra cycles per access, to stress requester stall handling.
  - Ordering and data results are unchanged.
- When not defined: the wait is always exactly WAIT_CYCLES and no LFSR logic exists.

Test Plan:
- Reset, WAIT_CYCLES=0: write addr 16'h0010, data 32'hDEADBEEF; request held until ready → ready one cycle after edge N+1, rdata=old word; then read 16'h0010 → rdata=32'hDEADBEEF, ready pulse one cycle.
- WAIT_CYCLES=3: read held continuously → ready exactly 4 edges after first sample; ready low in the DONE-following cycle; a held request starts a new access only from IDLE (period 6 cycles).
- Write and read both high, addr 16'h0004, old 32'h11111111, wdata 32'h22222222 → rdata=32'h11111111; a subsequent read returns 32'h22222222.
- DEPTH_LOG2=12, write to 16'h1000 → addr_err=1, ready pulses, RAM[0] unchanged; read 16'h1000 → rdata=0; addr_err stays 1 until rst.
- WAIT_CYCLES=5: write to 16'h0020 with rst asserted mid-BUSY → outputs 0 immediately (asynchronously); a later read of 16'h0020 returns its prior contents.
- DMEM_WAIT_LFSR_EN defined: 50 random reads and writes checked against a scoreboard → all data correct, waits vary within WAIT_CYCLES to WAIT_CYCLES+3.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed 32-bit data-memory responder: one access at a time, programmable wait, one-cycle ready pulse.
// Optional macro DMEM_WAIT_LFSR_EN adds 0-3 pseudo-random extra wait cycles per access.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ext_mem_addr,
    input  logic [31:0] ext_mem_wdata,
    input  logic        ext_mem_write,
    input  logic        ext_mem_read,
    output logic [31:0] ext_mem_rdata,
    output logic        ext_mem_ready,
    output logic        busy,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [15:0]             addr_q;
    logic [31:0]             wdata_q;
    logic                    write_q;
    logic [CNT_W-1:0]        cnt;
    logic [31:0]             mem [DEPTH];

    logic                    capture_c;
    logic                    exec_c;
    logic                    in_range_c;
    logic [DEPTH_LOG2-1:0]   ram_idx_c;
    logic [CNT_W-1:0]        load_val_c;

`ifdef DMEM_WAIT_LFSR_EN
    // Free-running x^7+x^6+1 LFSR jitters the wait to stress requester stalls.
    logic [6:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 7'h5A;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    assign load_val_c = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr[1:0]);
`else
    assign load_val_c = CNT_W'(WAIT_CYCLES);
`endif

    assign in_range_c = ((addr_q >> DEPTH_LOG2) == 16'd0);
    assign ram_idx_c  = addr_q[DEPTH_LOG2-1:0];

    // Next-state logic; DONE ignores inputs so a still-held request is not re-issued.
    always_comb begin
        state_next = state;
        capture_c  = 1'b0;
        exec_c     = 1'b0;
        case (state)
            IDLE: begin
                if (ext_mem_write || ext_mem_read) begin
                    capture_c  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    exec_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            cnt           <= '0;
            ext_mem_rdata <= '0;
            ext_mem_ready <= 1'b0;
            busy          <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            state         <= state_next;
            ext_mem_ready <= exec_c;
            busy          <= (state_next != IDLE);
            if (capture_c) begin
                addr_q  <= ext_mem_addr;
                wdata_q <= ext_mem_wdata;
                write_q <= ext_mem_write;
                cnt     <= load_val_c;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Read-before-write: rdata always returns the word as it was before this access.
            if (exec_c) begin
                if (in_range_c) begin
                    ext_mem_rdata <= mem[ram_idx_c];
                end else begin
                    ext_mem_rdata <= '0;
                    addr_err      <= 1'b1;
                end
            end
        end
    end

    // RAM is not reset; a write is committed only at a clean completion edge.
    always_ff @(posedge clk) begin
        if (exec_c && write_q && in_range_c && !rst) begin
            mem[ram_idx_c] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: two instances, WAIT_CYCLES=0 and WAIT_CYCLES=3.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr  [2];
    logic [31:0] wdata [2];
    logic        wr    [2];
    logic        rd    [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        busy  [2];
    logic        aerr  [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .ext_mem_addr(addr[0]), .ext_mem_wdata(wdata[0]),
        .ext_mem_write(wr[0]), .ext_mem_read(rd[0]),
        .ext_mem_rdata(rdata[0]), .ext_mem_ready(ready[0]),
        .busy(busy[0]), .addr_err(aerr[0])
    );

    dmem_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst),
        .ext_mem_addr(addr[1]), .ext_mem_wdata(wdata[1]),
        .ext_mem_write(wr[1]), .ext_mem_read(rd[1]),
        .ext_mem_rdata(rdata[1]), .ext_mem_ready(ready[1]),
        .busy(busy[1]), .addr_err(aerr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Edges from first sample to ready-visible: WAIT+2 (plus 0..3 with LFSR jitter).
    task automatic chk_lat(input string tag, input int d, input int lat, input int base);
`ifdef DMEM_WAIT_LFSR_EN
        chk(tag, 32'((lat >= base + wait_of(d)) && (lat <= base + wait_of(d) + 3)), 32'd1);
`else
        chk(tag, 32'(lat), 32'(base + wait_of(d)));
`endif
    endtask

    task automatic access(input int d, input logic w, input logic r, input logic [15:0] a,
                          input logic [31:0] wd, output logic [31:0] rdo, output int lat);
        @(negedge clk);
        addr[d]  = a;
        wdata[d] = wd;
        wr[d]    = w;
        rd[d]    = r;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) chk("busy_start", 32'(busy[d]), 32'd1);
        end while (!ready[d] && lat < 40);
        if (!ready[d]) chk("ready_timeout", 32'd0, 32'd1);
        rdo   = rdata[d];
        wr[d] = 1'b0;
        rd[d] = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_one_cycle", 32'(ready[d]), 32'd0);
        chk("busy_end", 32'(busy[d]), 32'd0);
    endtask

    logic [31:0] r;
    int          lat;
    int          n;
    logic [31:0] sb [16];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; wr[i] = 1'b0; rd[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdata", rdata[i], 32'd0);
            chk("rst_ready", 32'(ready[i]), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_addr_err", 32'(aerr[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // WAIT=0 write then read-back, with read-before-write data.
        access(0, 1'b1, 1'b0, 16'h0010, 32'h0000_0000, r, lat);
        access(0, 1'b1, 1'b0, 16'h0010, 32'hDEAD_BEEF, r, lat);
        chk_lat("w0_write_lat", 0, lat, 2);
        chk("w0_write_old", r, 32'h0000_0000);
        access(0, 1'b0, 1'b1, 16'h0010, 32'h0, r, lat);
        chk_lat("w0_read_lat", 0, lat, 2);
        chk("w0_read_data", r, 32'hDEAD_BEEF);

        // Write and read together act as a write returning the pre-write word.
        access(0, 1'b1, 1'b0, 16'h0004, 32'h1111_1111, r, lat);
        access(0, 1'b1, 1'b1, 16'h0004, 32'h2222_2222, r, lat);
        chk("both_old", r, 32'h1111_1111);
        access(0, 1'b0, 1'b1, 16'h0004, 32'h0, r, lat);
        chk("both_new", r, 32'h2222_2222);

        // Out-of-range write/read: dropped, zero data, sticky error.
        access(0, 1'b1, 1'b0, 16'h0000, 32'h1234_5678, r, lat);
        chk("oor_err_before", 32'(aerr[0]), 32'd0);
        access(0, 1'b1, 1'b0, 16'h1000, 32'hFFFF_FFFF, r, lat);
        chk_lat("oor_write_lat", 0, lat, 2);
        chk("oor_err_set", 32'(aerr[0]), 32'd1);
        access(0, 1'b0, 1'b1, 16'h0000, 32'h0, r, lat);
        chk("oor_ram0_kept", r, 32'h1234_5678);
        access(0, 1'b0, 1'b1, 16'h1000, 32'h0, r, lat);
        chk("oor_read_zero", r, 32'h0000_0000);
        chk("oor_err_sticky", 32'(aerr[0]), 32'd1);

        // WAIT=3 held read: first ready after 5 edges, then a new access every 6 edges.
        @(negedge clk);
        addr[1] = 16'h0100;
        rd[1]   = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 40);
        chk_lat("held_first_lat", 1, n, 2);
        @(posedge clk);
        #1;
        chk("held_ready_low", 32'(ready[1]), 32'd0);
        n = 1;
        do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 40);
        chk_lat("held_period", 1, n, 3);
        rd[1] = 1'b0;
        repeat (2) @(posedge clk);

        // Input changes during BUSY must not alter the captured access.
        access(1, 1'b1, 1'b0, 16'h0030, 32'hA5A5_A5A5, r, lat);
        access(1, 1'b1, 1'b0, 16'h0031, 32'h5A5A_5A5A, r, lat);
        @(negedge clk);
        addr[1] = 16'h0030;
        rd[1]   = 1'b1;
        @(posedge clk);
        #1;
        addr[1]  = 16'h0031;
        wdata[1] = 32'h0;
        wr[1]    = 1'b1;
        n = 1;
        do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 40);
        chk("busy_ignore_data", rdata[1], 32'hA5A5_A5A5);
        wr[1] = 1'b0;
        rd[1] = 1'b0;
        @(posedge clk);
        access(1, 1'b0, 1'b1, 16'h0031, 32'h0, r, lat);
        chk("busy_ignore_nowrite", r, 32'h5A5A_5A5A);

        // Reset mid-BUSY: outputs clear at once and the write is not committed.
        access(1, 1'b1, 1'b0, 16'h0020, 32'hCAFE_F00D, r, lat);
        access(1, 1'b0, 1'b1, 16'h0020, 32'h0, r, lat);
        chk("pre_rst_read", r, 32'hCAFE_F00D);
        @(negedge clk);
        addr[1]  = 16'h0020;
        wdata[1] = 32'hBAD0_BAD0;
        wr[1]    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy[1]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rdata", rdata[1], 32'd0);
        chk("async_busy", 32'(busy[1]), 32'd0);
        chk("async_ready", 32'(ready[1]), 32'd0);
        chk("async_err_clear", 32'(aerr[0]), 32'd0);
        wr[1] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        access(1, 1'b0, 1'b1, 16'h0020, 32'h0, r, lat);
        chk("abort_no_write", r, 32'hCAFE_F00D);

        // Random reads/writes against a scoreboard; wait may jitter when the LFSR is enabled.
        for (int i = 0; i < 16; i++) begin
            sb[i] = $urandom;
            access(1, 1'b1, 1'b0, 16'(16'h0200 + i), sb[i], r, lat);
        end
        for (int k = 0; k < 50; k++) begin
            int          idx;
            logic [31:0] d;
            idx = int'($urandom_range(0, 15));
            d   = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                access(1, 1'b1, 1'b0, 16'(16'h0200 + idx), d, r, lat);
                chk("rand_write_old", r, sb[idx]);
                sb[idx] = d;
            end else begin
                access(1, 1'b0, 1'b1, 16'(16'h0200 + idx), 32'h0, r, lat);
                chk("rand_read", r, sb[idx]);
            end
            chk_lat("rand_lat", 1, lat, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
